// File: rtl/mem_stage_ctrl_if.sv
// Data-cache port between the MEM-stage controller (master) and the cache (slave).
interface mem_stage_ctrl_if;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        dhit;
    logic [31:0] dmemload;

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  dhit, dmemload
    );

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        output dhit, dmemload
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues data-cache requests, stalls until dhit, selects and
// registers write-back fields, and flags misaligned/timed-out accesses and halt.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ex_valid,
    input  logic [31:0]      aluOutport_in,
    input  logic [31:0]      rdat2_in,
    input  logic [31:0]      pcplus4_in,
    input  logic [4:0]       rt_in,
    input  logic [4:0]       rd_in,
    input  logic             MemToReg_in,
    input  logic             RegDst_in,
    input  logic             JType_in,
    input  logic             regWEN_in,
    input  logic             Halt_in,
    input  logic             dMemREN_in,
    input  logic             dMemWEN_in,
    mem_stage_ctrl_if.master dcache,
    output logic             mem_stall,
    output logic [4:0]       wb_wsel,
    output logic [31:0]      wb_wdat,
    output logic             wb_regWEN,
    output logic             halt_out,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

    localparam int unsigned            WCNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [WCNT_W-1:0]      WAIT_LAST = WCNT_W'(TIMEOUT - 1);

    state_t            state, state_n;
    logic [WCNT_W-1:0] wait_cnt, wait_nxt;
    logic              acc, mis, req_ok;
    logic [4:0]        wsel;
    logic [31:0]       wdat;

    // RST gates the requests so an in-flight access is dropped in the reset cycle itself.
    always_comb begin
        acc    = !RST && ex_valid && (dMemREN_in || dMemWEN_in) && !halt_out && (state != ERR);
        mis    = acc && (aluOutport_in[1:0] != 2'b00);
        req_ok = acc && !mis;
    end

    assign dcache.dmemWEN   = req_ok & dMemWEN_in;
    assign dcache.dmemREN   = req_ok & dMemREN_in & ~dMemWEN_in;
    assign dcache.dmemaddr  = aluOutport_in;
    assign dcache.dmemstore = rdat2_in;

    assign mem_stall = req_ok & ~dcache.dhit;
    assign mem_err   = (state == ERR);
    assign wait_nxt  = wait_cnt + WCNT_W'(1);

    always_comb begin
        wsel = JType_in ? 5'd31 : (RegDst_in ? rd_in : rt_in);
        if (MemToReg_in)
            wdat = dcache.dmemload;
        else
            wdat = JType_in ? pcplus4_in : aluOutport_in;
    end

    // Timeout fires on the cycle the wait counter would reach TIMEOUT-1, so the access
    // stalls for exactly TIMEOUT cycles including the first (IDLE) cycle.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (mis)
                    state_n = ERR;
                else if (mem_stall)
                    state_n = WAIT;
            end
            WAIT: begin
                if (mis)
                    state_n = ERR;
                else if (!acc || dcache.dhit)
                    state_n = IDLE;
                else if (wait_nxt == WAIT_LAST)
                    state_n = ERR;
            end
            ERR:     state_n = ERR;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= (state == WAIT) ? wait_nxt : '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wb_wsel   <= '0;
            wb_wdat   <= '0;
            wb_regWEN <= 1'b0;
            halt_out  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (mem_stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (!mem_stall) begin
                wb_wsel   <= wsel;
                wb_wdat   <= wdat;
                wb_regWEN <= ex_valid && regWEN_in && !mis && (state != ERR) && !halt_out;
                if (ex_valid && Halt_in)
                    halt_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl (TIMEOUT=8, CNT_W=4 to reach the boundaries).
module tb_mem_stage_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ex_valid;
    logic [31:0] aluOutport_in, rdat2_in, pcplus4_in;
    logic [4:0]  rt_in, rd_in;
    logic        MemToReg_in, RegDst_in, JType_in, regWEN_in, Halt_in, dMemREN_in, dMemWEN_in;
    logic        mem_stall, wb_regWEN, halt_out, mem_err;
    logic [4:0]  wb_wsel;
    logic [31:0] wb_wdat;
    logic [3:0]  stall_cnt;

    int errors = 0;
    int checks = 0;

    mem_stage_ctrl_if dc();

    mem_stage_ctrl #(.TIMEOUT(8), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST), .ex_valid(ex_valid),
        .aluOutport_in(aluOutport_in), .rdat2_in(rdat2_in), .pcplus4_in(pcplus4_in),
        .rt_in(rt_in), .rd_in(rd_in),
        .MemToReg_in(MemToReg_in), .RegDst_in(RegDst_in), .JType_in(JType_in),
        .regWEN_in(regWEN_in), .Halt_in(Halt_in), .dMemREN_in(dMemREN_in), .dMemWEN_in(dMemWEN_in),
        .dcache(dc),
        .mem_stall(mem_stall), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat), .wb_regWEN(wb_regWEN),
        .halt_out(halt_out), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        ex_valid = 0; aluOutport_in = '0; rdat2_in = '0; pcplus4_in = '0;
        rt_in = '0; rd_in = '0; MemToReg_in = 0; RegDst_in = 0; JType_in = 0;
        regWEN_in = 0; Halt_in = 0; dMemREN_in = 0; dMemWEN_in = 0;
        dc.dhit = 0; dc.dmemload = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        RST = 1;
        tick();
        RST = 0;
        #1;
    endtask

    task automatic set_load(input logic [31:0] addr, input logic [4:0] rt);
        clear_inputs();
        ex_valid = 1; aluOutport_in = addr; dMemREN_in = 1; MemToReg_in = 1;
        regWEN_in = 1; rt_in = rt;
    endtask

    task automatic test_reset();
        clear_inputs();
        RST = 1;
        tick(); tick();
        checks++; if (wb_wsel !== 5'd0) begin errors++; $display("FAIL rst_wsel got=%0h exp=0", wb_wsel); end
        checks++; if (wb_wdat !== 32'd0) begin errors++; $display("FAIL rst_wdat got=%0h exp=0", wb_wdat); end
        checks++; if (wb_regWEN !== 1'b0) begin errors++; $display("FAIL rst_regwen got=%0b exp=0", wb_regWEN); end
        checks++; if (halt_out !== 1'b0) begin errors++; $display("FAIL rst_halt got=%0b exp=0", halt_out); end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%0b exp=0", mem_err); end
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", stall_cnt); end
        RST = 0;
        #1;
    endtask

    task automatic test_load_hit();
        set_load(32'h100, 5'd5);
        dc.dhit = 1; dc.dmemload = 32'hDEADBEEF;
        #1;
        checks++; if (dc.dmemREN !== 1'b1) begin errors++; $display("FAIL ld_ren got=%0b exp=1", dc.dmemREN); end
        checks++; if (dc.dmemaddr !== 32'h100) begin errors++; $display("FAIL ld_addr got=%0h exp=100", dc.dmemaddr); end
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL ld_stall got=%0b exp=0", mem_stall); end
        tick();
        checks++; if (wb_wsel !== 5'd5) begin errors++; $display("FAIL ld_wsel got=%0d exp=5", wb_wsel); end
        checks++; if (wb_wdat !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_wdat got=%0h exp=deadbeef", wb_wdat); end
        checks++; if (wb_regWEN !== 1'b1) begin errors++; $display("FAIL ld_regwen got=%0b exp=1", wb_regWEN); end
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL ld_cnt got=%0d exp=0", stall_cnt); end
    endtask

    // Back-to-back after the load; REN and WEN both set so the write must win.
    task automatic test_store_wait();
        clear_inputs();
        ex_valid = 1; aluOutport_in = 32'h200; rdat2_in = 32'h1234;
        dMemWEN_in = 1; dMemREN_in = 1; rt_in = 5'd7;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (dc.dmemWEN !== 1'b1) begin errors++; $display("FAIL st_wen[%0d] got=%0b exp=1", i, dc.dmemWEN); end
            checks++; if (dc.dmemREN !== 1'b0) begin errors++; $display("FAIL st_ren[%0d] got=%0b exp=0", i, dc.dmemREN); end
            checks++; if (dc.dmemaddr !== 32'h200 || dc.dmemstore !== 32'h1234) begin errors++; $display("FAIL st_bus[%0d] got=%0h/%0h exp=200/1234", i, dc.dmemaddr, dc.dmemstore); end
            checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL st_stall[%0d] got=%0b exp=1", i, mem_stall); end
            tick();
            checks++; if (wb_wsel !== 5'd5 || wb_wdat !== 32'hDEADBEEF) begin errors++; $display("FAIL st_hold[%0d] got=%0d/%0h exp=5/deadbeef", i, wb_wsel, wb_wdat); end
        end
        dc.dhit = 1;
        #1;
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL st_hit_stall got=%0b exp=0", mem_stall); end
        tick();
        checks++; if (wb_wsel !== 5'd7 || wb_wdat !== 32'h200 || wb_regWEN !== 1'b0) begin errors++; $display("FAIL st_wb got=%0d/%0h/%0b exp=7/200/0", wb_wsel, wb_wdat, wb_regWEN); end
        checks++; if (stall_cnt !== 4'd3) begin errors++; $display("FAIL st_cnt got=%0d exp=3", stall_cnt); end
    endtask

    // Unaligned ALU result without a memory op must not raise an error.
    task automatic test_jal_regdst();
        clear_inputs();
        ex_valid = 1; JType_in = 1; pcplus4_in = 32'h44; regWEN_in = 1;
        RegDst_in = 1; rd_in = 5'd3; aluOutport_in = 32'h999;
        #1;
        checks++; if (dc.dmemREN !== 1'b0 || dc.dmemWEN !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL jal_req got=%0b%0b%0b exp=000", dc.dmemREN, dc.dmemWEN, mem_stall); end
        tick();
        checks++; if (wb_wsel !== 5'd31 || wb_wdat !== 32'h44 || wb_regWEN !== 1'b1) begin errors++; $display("FAIL jal_wb got=%0d/%0h/%0b exp=31/44/1", wb_wsel, wb_wdat, wb_regWEN); end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL jal_err got=%0b exp=0", mem_err); end
        JType_in = 0; rd_in = 5'd9; aluOutport_in = 32'hABCD;
        tick();
        checks++; if (wb_wsel !== 5'd9 || wb_wdat !== 32'hABCD) begin errors++; $display("FAIL rdst_wb got=%0d/%0h exp=9/abcd", wb_wsel, wb_wdat); end
    endtask

    // Two 7-stall loads (hit on the last cycle before timeout) saturate the 4-bit counter.
    task automatic test_long_wait_saturate();
        logic [3:0] exp_cnt [2];
        exp_cnt[0] = 4'd10;
        exp_cnt[1] = 4'd15;
        for (int n = 0; n < 2; n++) begin
            set_load(32'h300 + 32'(n * 4), 5'(8 + n));
            for (int i = 0; i < 7; i++) begin
                #1;
                checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL lw%0d_stall[%0d] got=%0b exp=1", n, i, mem_stall); end
                tick();
            end
            dc.dhit = 1; dc.dmemload = 32'h55 + 32'(n);
            tick();
            checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL lw%0d_err got=%0b exp=0", n, mem_err); end
            checks++; if (wb_wdat !== 32'h55 + 32'(n) || wb_wsel !== 5'(8 + n)) begin errors++; $display("FAIL lw%0d_wb got=%0d/%0h exp=%0d/%0h", n, wb_wsel, wb_wdat, 8 + n, 32'h55 + 32'(n)); end
            checks++; if (stall_cnt !== exp_cnt[n]) begin errors++; $display("FAIL lw%0d_cnt got=%0d exp=%0d", n, stall_cnt, exp_cnt[n]); end
        end
    endtask

    task automatic test_timeout();
        set_load(32'h400, 5'd2);
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL to_stall[%0d] got=%0b exp=1", i, mem_stall); end
            tick();
        end
        #1;
        checks++; if (mem_stall !== 1'b0 || dc.dmemREN !== 1'b0) begin errors++; $display("FAIL to_after got=%0b/%0b exp=0/0", mem_stall, dc.dmemREN); end
        checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL to_err got=%0b exp=1", mem_err); end
        tick();
        checks++; if (wb_regWEN !== 1'b0 || stall_cnt !== 4'd15) begin errors++; $display("FAIL to_wb got=%0b/%0d exp=0/15", wb_regWEN, stall_cnt); end
    endtask

    task automatic test_misaligned();
        do_reset();
        set_load(32'h102, 5'd4);
        dc.dhit = 1;
        #1;
        checks++; if (dc.dmemREN !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL mis_req got=%0b/%0b exp=0/0", dc.dmemREN, mem_stall); end
        tick();
        checks++; if (mem_err !== 1'b1 || wb_regWEN !== 1'b0) begin errors++; $display("FAIL mis_state got=%0b/%0b exp=1/0", mem_err, wb_regWEN); end
        aluOutport_in = 32'h104;
        #1;
        checks++; if (dc.dmemREN !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL mis_later got=%0b/%0b exp=0/0", dc.dmemREN, mem_stall); end
        tick();
        checks++; if (wb_regWEN !== 1'b0 || mem_err !== 1'b1) begin errors++; $display("FAIL mis_later_wb got=%0b/%0b exp=0/1", wb_regWEN, mem_err); end
    endtask

    task automatic test_halt();
        do_reset();
        clear_inputs();
        ex_valid = 1; Halt_in = 1;
        tick();
        checks++; if (halt_out !== 1'b1) begin errors++; $display("FAIL halt_set got=%0b exp=1", halt_out); end
        set_load(32'h100, 5'd6);
        #1;
        checks++; if (dc.dmemREN !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL halt_ld got=%0b/%0b exp=0/0", dc.dmemREN, mem_stall); end
        tick();
        checks++; if (wb_regWEN !== 1'b0 || halt_out !== 1'b1) begin errors++; $display("FAIL halt_wb got=%0b/%0b exp=0/1", wb_regWEN, halt_out); end
        do_reset();
        set_load(32'h101, 5'd6);
        Halt_in = 1;
        #1;
        checks++; if (dc.dmemREN !== 1'b0) begin errors++; $display("FAIL mishalt_ren got=%0b exp=0", dc.dmemREN); end
        tick();
        checks++; if (halt_out !== 1'b1 || mem_err !== 1'b1) begin errors++; $display("FAIL mishalt got=%0b/%0b exp=1/1", halt_out, mem_err); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        set_load(32'h100, 5'd5);
        tick(); tick();
        checks++; if (dc.dmemREN !== 1'b1 || mem_stall !== 1'b1) begin errors++; $display("FAIL rw_pre got=%0b/%0b exp=1/1", dc.dmemREN, mem_stall); end
        RST = 1;
        #1;
        checks++; if (dc.dmemREN !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL rw_drop got=%0b/%0b exp=0/0", dc.dmemREN, mem_stall); end
        checks++; if (stall_cnt !== 4'd0 || wb_wsel !== 5'd0 || wb_wdat !== 32'd0 || wb_regWEN !== 1'b0 || halt_out !== 1'b0 || mem_err !== 1'b0) begin errors++; $display("FAIL rw_regs got=%0d/%0d/%0h/%0b/%0b/%0b exp=all 0", stall_cnt, wb_wsel, wb_wdat, wb_regWEN, halt_out, mem_err); end
        clear_inputs();
        tick();
        RST = 0;
        #1;
    endtask

    initial begin
        test_reset();
        test_load_hit();
        test_store_wait();
        test_jal_regdst();
        test_long_wait_saturate();
        test_timeout();
        test_misaligned();
        test_halt();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
